// File: rtl/rice_core_fetch_unit.sv
// Rice core fetch front end: aligned block fetch with credit-limited outstanding requests,
// a block FIFO and one-instruction-per-cycle issue. Optional fault tracking: RICE_CORE_FETCH_BUS_ERROR_EN.

module rice_core_fetch_unit_checker #(
    parameter int unsigned IW = 2
) (
    input logic          i_clk,
    input logic          i_rst_n,
    input logic          i_rsp_valid,
    input logic [IW-1:0] i_inflight
);
    // A response with nothing outstanding means the bus produced a beat nobody asked for
    rsp_without_request_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_rsp_valid && (i_inflight == '0)));
endmodule

module rice_core_fetch_unit #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     FETCH_WIDTH     = 2,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] INITIAL_PC      = 32'h8000_0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic [XLEN-1:0]          i_flush_pc,
    output logic                     o_req_valid,
    input  logic                     i_req_ready,
    output logic [XLEN-1:0]          o_req_address,
    input  logic                     i_rsp_valid,
    input  logic [32*FETCH_WIDTH-1:0] i_rsp_data,
`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
    input  logic                     i_rsp_error,
    output logic                     o_inst_fault,
`endif
    output logic                     o_inst_valid,
    input  logic                     i_inst_ready,
    output logic [XLEN-1:0]          o_inst_pc,
    output logic [31:0]              o_inst
);
    localparam int unsigned BB   = 4 * FETCH_WIDTH;
    localparam int unsigned OFFW = $clog2(BB);
    localparam int unsigned SW   = $clog2(FETCH_WIDTH);
    localparam int unsigned SLW  = (SW > 0) ? SW : 1;
    localparam int unsigned DW   = 32 * FETCH_WIDTH;
    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW   = $clog2(MAX_OUTSTANDING + 1);

    function automatic logic [XLEN-1:0] align_f(input logic [XLEN-1:0] a);
        align_f = {a[XLEN-1:OFFW], {OFFW{1'b0}}};
    endfunction

    function automatic logic [SLW-1:0] slot_of_f(input logic [XLEN-1:0] a);
        slot_of_f = SLW'((a >> 2) & XLEN'(FETCH_WIDTH - 1));
    endfunction

    function automatic logic [PW-1:0] next_ptr_f(input logic [PW-1:0] p);
        next_ptr_f = (p == PW'(FIFO_DEPTH - 1)) ? PW'(0) : p + PW'(1);
    endfunction

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, pc_out_q, pc_out_d;
    logic [IW-1:0]   inflight_q, inflight_d, stale_q, stale_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [SLW-1:0]  slot_q, slot_d, rslot_q, rslot_d;
    logic            first_q, first_d;
    logic [DW-1:0]   fifo_data_q  [FIFO_DEPTH];
    logic [SLW-1:0]  fifo_start_q [FIFO_DEPTH];

    logic            redirect_s, req_valid_s, req_ack_s, push_s, pop_s;
    logic            accept_s, inst_valid_s, last_slot_s, halt_block_s;
    logic [XLEN-1:0] redirect_pc_s, req_addr_s;
    logic [SLW-1:0]  slot_idx_s, push_start_s;
    logic [31:0]     credit_s;

`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
    logic fifo_fault_q [FIFO_DEPTH];
    logic halt_q, halt_d;
    // A flush in the same cycle lifts the fault halt so the redirect request can go out
    assign halt_block_s = halt_q && !i_flush;
    assign o_inst_fault = inst_valid_s && fifo_fault_q[rd_ptr_q];
`else
    assign halt_block_s = 1'b0;
`endif

    // Request credits, FIFO handshakes and issue selection
    always_comb begin
        redirect_s    = i_flush || !i_enable;
        redirect_pc_s = i_enable ? i_flush_pc : INITIAL_PC;
        req_addr_s    = align_f(i_flush ? i_flush_pc : fetch_pc_q);
        // Stale beats never reach the FIFO, so only live requests consume buffer credit
        credit_s      = 32'(inflight_q) - 32'(stale_q) + 32'(count_q);
        req_valid_s   = i_enable && (inflight_q < IW'(MAX_OUTSTANDING))
                        && (credit_s < 32'(FIFO_DEPTH)) && !halt_block_s;
        req_ack_s     = req_valid_s && i_req_ready;
        push_s        = i_rsp_valid && (stale_q == '0) && !redirect_s;
        push_start_s  = first_q ? rslot_q : SLW'(0);
        slot_idx_s    = fifo_start_q[rd_ptr_q] + slot_q;
        last_slot_s   = (slot_idx_s == SLW'(FETCH_WIDTH - 1));
        inst_valid_s  = (count_q != '0) && !redirect_s;
        accept_s      = inst_valid_s && i_inst_ready;
        pop_s         = accept_s && last_slot_s;
    end

    assign o_req_valid   = req_valid_s;
    assign o_req_address = req_addr_s;
    assign o_inst_valid  = inst_valid_s;
    assign o_inst_pc     = pc_out_q;
    assign o_inst        = fifo_data_q[rd_ptr_q][slot_idx_s*32 +: 32];

    // Next-state for fetch PC, credit counters, FIFO pointers and issue cursor
    always_comb begin
        if (!i_enable) begin
            fetch_pc_d = INITIAL_PC;
        end else if (req_ack_s) begin
            fetch_pc_d = req_addr_s + XLEN'(BB);
        end else if (i_flush) begin
            fetch_pc_d = i_flush_pc;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        inflight_d = inflight_q + IW'(req_ack_s) - IW'(i_rsp_valid);

        if (redirect_s) begin
            stale_d = inflight_q - IW'(i_rsp_valid);
        end else if (i_rsp_valid && (stale_q != '0)) begin
            stale_d = stale_q - IW'(1);
        end else begin
            stale_d = stale_q;
        end

        if (redirect_s) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            slot_d   = '0;
            pc_out_d = redirect_pc_s;
            first_d  = 1'b1;
            rslot_d  = slot_of_f(redirect_pc_s);
        end else begin
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
            rd_ptr_d = pop_s ? next_ptr_f(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d = push_s ? next_ptr_f(wr_ptr_q) : wr_ptr_q;
            if (accept_s) begin
                slot_d   = last_slot_s ? SLW'(0) : slot_q + SLW'(1);
                pc_out_d = pc_out_q + XLEN'(4);
            end else begin
                slot_d   = slot_q;
                pc_out_d = pc_out_q;
            end
            first_d  = push_s ? 1'b0 : first_q;
            rslot_d  = rslot_q;
        end
    end

`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
    // Fault halt: raised by a live erroring beat, cleared by any redirect
    always_comb begin
        if (redirect_s) begin
            halt_d = 1'b0;
        end else if (push_s && i_rsp_error) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_q;
        end
    end
`endif

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q <= INITIAL_PC;
            pc_out_q   <= INITIAL_PC;
            inflight_q <= '0;
            stale_q    <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            slot_q     <= '0;
            first_q    <= 1'b1;
            rslot_q    <= slot_of_f(INITIAL_PC);
`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
            halt_q     <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_out_q   <= pc_out_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            slot_q     <= slot_d;
            first_q    <= first_d;
            rslot_q    <= rslot_d;
`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
            halt_q     <= halt_d;
`endif
        end
    end

    // Block storage; contents are only observed while count_q marks them valid
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_data_q[wr_ptr_q]  <= i_rsp_data;
            fifo_start_q[wr_ptr_q] <= push_start_s;
`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
            fifo_fault_q[wr_ptr_q] <= i_rsp_error;
`endif
        end
    end

    rice_core_fetch_unit_checker #(.IW(IW)) u_checker (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rsp_valid (i_rsp_valid),
        .i_inflight  (inflight_q)
    );
endmodule

// File: tb/tb_rice_core_fetch_unit.sv
// Randomized bench for rice_core_fetch_unit: an in-order memory responder plus a stream model
// (after a redirect to P the issued stream is P, P+4, ... holding the memory word at each PC).
module tb_rice_core_fetch_unit;
    localparam logic [31:0] INIT_PC = 32'h8000_0000;
    localparam int          MAXO    = 2;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b0;
    logic        flush      = 1'b0;
    logic [31:0] flush_pc   = 32'h0;
    logic        req_ready  = 1'b0;
    logic        rsp_valid  = 1'b0;
    logic [63:0] rsp_data   = 64'h0;
    logic        inst_ready = 1'b0;
    logic        req_valid, inst_valid;
    logic [31:0] req_address, inst_pc, inst;
`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
    logic        rsp_error  = 1'b0;
    logic        inst_fault;
`endif

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          n_acks    = 0;
    int          n_accepts = 0;
    logic        obs_valid = 1'b0;
    logic [31:0] exp_pc    = INIT_PC;
    logic [31:0] exp_fetch = INIT_PC;
    logic [31:0] out_q [$];

    always #5 clk = ~clk;

    rice_core_fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_flush       (flush),
        .i_flush_pc    (flush_pc),
        .o_req_valid   (req_valid),
        .i_req_ready   (req_ready),
        .o_req_address (req_address),
        .i_rsp_valid   (rsp_valid),
        .i_rsp_data    (rsp_data),
`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
        .i_rsp_error   (rsp_error),
        .o_inst_fault  (inst_fault),
`endif
        .o_inst_valid  (inst_valid),
        .i_inst_ready  (inst_ready),
        .o_inst_pc     (inst_pc),
        .o_inst        (inst)
    );

    function automatic logic [31:0] inst_at(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_0F0F;
    endfunction

    function automatic logic [31:0] blk(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, update the model for the coming posedge.
    task automatic step(input logic f, input logic [31:0] fpc, input logic en,
                        input logic ir, input logic rr, input int rsp_pct);
        logic        redir;
        logic [31:0] a;
        logic [31:0] ea;
        @(negedge clk);
        flush      = f;
        flush_pc   = fpc;
        enable     = en;
        inst_ready = ir;
        req_ready  = rr;
        rsp_valid  = (out_q.size() > 0) && ($urandom_range(99) < rsp_pct);
        a = (out_q.size() > 0) ? out_q[0] : 32'h0;
        for (int k = 0; k < 2; k++) rsp_data[32*k +: 32] = inst_at(a + 32'(4*k));
        #1;
        redir     = f || !en;
        obs_valid = inst_valid;
        if (redir) begin
            check_eq("valid_during_redirect", {31'd0, inst_valid}, 32'd0);
        end else if (inst_valid) begin
            check_eq("inst_pc", inst_pc, exp_pc);
            check_eq("inst_data", inst, inst_at(exp_pc));
`ifdef RICE_CORE_FETCH_BUS_ERROR_EN
            check_eq("inst_fault", {31'd0, inst_fault}, 32'd0);
`endif
            if (ir) begin
                exp_pc = exp_pc + 32'd4;
                n_accepts++;
            end
        end
        if (f) check_eq("flush_req_addr", req_address, blk(fpc));
        if (!en) check_eq("req_valid_disabled", {31'd0, req_valid}, 32'd0);
        if (req_valid) check_eq("outstanding_limit", {31'd0, out_q.size() < MAXO}, 32'd1);
        if (req_valid && rr) begin
            ea = f ? blk(fpc) : exp_fetch;
            check_eq("req_addr", req_address, ea);
            out_q.push_back(ea);
            exp_fetch = ea + 32'd8;
            n_acks++;
        end else if (!en) begin
            exp_fetch = INIT_PC;
        end else if (f) begin
            exp_fetch = blk(fpc);
        end
        if (rsp_valid) void'(out_q.pop_front());
        if (redir) exp_pc = en ? fpc : INIT_PC;
    endtask

    // Drain everything, then leave exactly two requests outstanding with an empty buffer.
    task automatic hold_two();
        for (int c = 0; c < 14; c++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 100);
        for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 0);
        check_eq("two_in_flight", out_q.size(), 32'd2);
    endtask

    initial begin
        int first;
        int a0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst_pc", inst_pc, INIT_PC);
        @(negedge clk);
        rst_n = 1'b1;

        // Enable with a one-cycle memory: back-to-back issue from 0x8000_0000
        first = -1;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 100);
            if (first < 0 && obs_valid) first = c;
        end
        check_eq("first_valid_latency", first, 32'd2);

        // Flush with two requests in flight; both old beats must be dropped
        hold_two();
        step(1'b1, 32'h8000_0104, 1'b1, 1'b1, 1'b1, 0);
        for (int c = 0; c < 12; c++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 100);

        // Decode stalled: the buffer depth bounds the number of live requests
        a0 = n_acks;
        step(1'b1, 32'h8000_0200, 1'b1, 1'b0, 1'b1, 100);
        for (int c = 0; c < 20; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 100);
        check_eq("stall_block_requests", n_acks - a0, 32'd4);
        for (int c = 0; c < 20; c++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 100);

        // Enable dropped for one cycle with two in flight: refetch from the reset PC
        hold_two();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0);
        for (int c = 0; c < 16; c++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 100);

        // Random traffic, flushes landing on responses and acks included
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(29) == 0,
                 INIT_PC + {20'd0, 10'($urandom_range(1023)), 2'b00},
                 $urandom_range(49) != 0,
                 $urandom_range(3) != 0,
                 $urandom_range(2) != 0,
                 60);
        end

        a0 = n_accepts;
        for (int c = 0; c < 40; c++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 100);
        check_eq("drain_progress", {31'd0, n_accepts > a0}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
